// File: rtl/scrambler_pkg.sv
// Shared types and defaults for the RO-PUF challenge scrambler.
package scrambler_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } scr_state_t;

    localparam logic [7:0]  SCR_DEFAULT_TAPS = 8'h8F;
    localparam int unsigned SCR_DEFAULT_NL_A = 6;
    localparam int unsigned SCR_DEFAULT_NL_B = 5;

endpackage

// File: rtl/scrambler_round.sv
// One combinational shift-XOR round: linear tap parity plus a single AND term,
// folded into the MSB of the shifted state.
module scrambler_round #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h8F,
    parameter int unsigned      NL_A  = 6,
    parameter int unsigned      NL_B  = 5
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_next
);

    logic w_fb;

    assign w_fb   = (^(i_state & TAPS)) ^ (i_state[NL_A] & i_state[NL_B]);
    assign o_next = i_state ^ {w_fb, i_state[WIDTH-1:1]};

endmodule

// File: rtl/challenge_scrambler.sv
// Handshaked challenge scrambler: load, ROUNDS update rounds, hold until taken.
// Define SCRAMBLER_KEY_EN to add the in_key whitening port.
module challenge_scrambler
    import scrambler_pkg::*;
#(
    parameter int unsigned      WIDTH  = 8,
    parameter int unsigned      ROUNDS = 3,
    parameter logic [WIDTH-1:0] TAPS   = SCR_DEFAULT_TAPS,
    parameter int unsigned      NL_A   = SCR_DEFAULT_NL_A,
    parameter int unsigned      NL_B   = SCR_DEFAULT_NL_B
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_challenge,
`ifdef SCRAMBLER_KEY_EN
    input  logic [WIDTH-1:0] in_key,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_challenge,
    output logic             busy
);

    localparam int unsigned     CNT_W = $clog2(ROUNDS + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(ROUNDS - 1);

    scr_state_t       r_fsm;
    scr_state_t       w_fsm_next;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_state_next;
    logic [WIDTH-1:0] w_round;
    logic [WIDTH-1:0] w_load;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

`ifdef SCRAMBLER_KEY_EN
    assign w_load = in_challenge ^ in_key;
`else
    assign w_load = in_challenge;
`endif

    scrambler_round #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .NL_A  (NL_A),
        .NL_B  (NL_B)
    ) u_round (
        .i_state (r_state),
        .o_next  (w_round)
    );

    always_comb begin
        w_fsm_next   = r_fsm;
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_fsm)
            StIdle: begin
                if (in_valid) begin
                    w_state_next = w_load;
                    w_cnt_next   = '0;
                    w_fsm_next   = StRun;
                end
            end
            StRun: begin
                w_state_next = w_round;
                w_cnt_next   = r_cnt + CNT_W'(1);
                if (r_cnt == LAST) begin
                    w_fsm_next = StDone;
                end
            end
            StDone: begin
                // Return to idle only; a new challenge waits for the next cycle.
                if (out_ready) begin
                    w_fsm_next = StIdle;
                end
            end
            default: w_fsm_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= StIdle;
            r_state <= '0;
            r_cnt   <= '0;
        end else begin
            r_fsm   <= w_fsm_next;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign in_ready      = (r_fsm == StIdle);
    assign busy          = (r_fsm == StRun);
    assign out_valid     = (r_fsm == StDone);
    assign out_challenge = r_state;

endmodule

// File: doc/challenge_scrambler.md
# challenge_scrambler

Parametrised, handshaked challenge scrambler for the ring-oscillator PUF. It accepts a WIDTH-bit challenge and applies ROUNDS iterations of a shift-XOR update with a configurable linear tap mask and one nonlinear AND term. It then holds the scrambled challenge until the downstream consumer (RO pair selector) takes it. It sits between the challenge source and the RO mux/compare path.

## Interface
- WIDTH, 8: challenge/state width; must be ≥ 4.
- ROUNDS, 3: update rounds per challenge; must be ≥ 1.
- TAPS, 8'h8F: linear feedback tap mask, WIDTH bits; bit i set means state[i] feeds the feedback bit.
- NL_A, 6: first index of the nonlinear AND term.
- NL_B, 5: second index of the nonlinear AND term; must differ from NL_A.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input challenge valid.
- in_ready  output  1  block can accept a challenge.
- in_challenge  input  WIDTH  raw challenge.
- in_key  input  WIDTH  whitening key; present only with SCRAMBLER_KEY_EN.
- out_valid  output  1  scrambled challenge valid.
- out_ready  input  1  consumer accepts the output.
- out_challenge  output  WIDTH  scrambled challenge; registered.
- busy  output  1  high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE. Registers: state[WIDTH-1:0] and round counter cnt, width $clog2(ROUNDS+1).
- Round function, combinational:
  - fb = ^(state & TAPS) ^ (state[NL_A] & state[NL_B]).
  - next = state ^ {fb, state[WIDTH-1:1]}.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: state <= in_challenge (XOR in_key when the macro is enabled), cnt <= 0, go to RUN.
- RUN:
  - Each cycle: state <= next, cnt <= cnt+1.
  - On the cycle with cnt == ROUNDS-1, the last round is applied and the FSM goes to DONE.
  - in_valid is ignored in RUN; in_ready = 0.
- DONE:
  - out_valid = 1 and out_challenge = state, held stable while out_ready = 0.
  - On out_valid & out_ready: go to IDLE. No new challenge is accepted in the same cycle.
- out_challenge always reflects state, including in IDLE and RUN. Consumers use it only when out_valid = 1.
- Boundary conditions:
  - All-zero input (key-XORed when enabled) is a fixed point; output 0. This is not flagged.
  - Changes on in_challenge after acceptance have no effect.
  - rst_n low in any state forces IDLE immediately, with state = 0 and cnt = 0. The in-flight challenge is discarded without output.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_challenge = 0, busy = 0.
- Accept at edge E0. Rounds are applied at edges E1…E_ROUNDS. out_valid rises after E_ROUNDS, i.e. latency = ROUNDS cycles from the accept edge.
- With out_ready tied high: out_valid stays high for 1 cycle, and in_ready returns the cycle after.
- Peak throughput: one challenge per ROUNDS+2 cycles.
- in_ready, out_valid and busy decode from FSM state only; there is no combinational path from any input.

## Configuration
- SCRAMBLER_KEY_EN defined: the in_key port exists, and the load value is in_challenge ^ in_key.
- SCRAMBLER_KEY_EN undefined: there is no in_key port, and the load value is in_challenge.
- All other behaviour and timing are identical in both builds.

## Structure
- scrambler_pkg contains:
  - scr_state_t enum (IDLE, RUN, DONE).
  - localparam SCR_DEFAULT_TAPS = 8'h8F.
  - Default NL indices.
- Sub-module scrambler_round: purely combinational round function, parameters WIDTH/TAPS/NL_A/NL_B, state in, next out. It is instantiated once and is reusable by a future unrolled variant.

## Test plan
- Defaults, in_challenge = 8'h01, out_ready = 1 → out_valid exactly 3 cycles after accept, out_challenge = 8'hA1 (0x01 → 0x81 → 0xC1 → 0xA1).
- in_challenge = 8'h00 → out_challenge = 8'h00 after 3 cycles; in_ready stays 0 during RUN/DONE even with in_valid held high.
- out_ready held 0 for 10 cycles after out_valid → out_challenge stable at 8'hA1, out_valid stays high; release → IDLE next cycle, in_ready = 1.
- rst_n pulsed low during RUN (after 1 round) → outputs immediately at reset values, no out_valid; the next challenge 8'h01 produces 8'hA1.
- SCRAMBLER_KEY_EN build, in_challenge = 8'h00, in_key = 8'h01 → out_challenge = 8'hA1.
- ROUNDS = 1, in_challenge = 8'h01 → out_challenge = 8'h81, out_valid 1 cycle after accept.
